// File: rtl/framebuffer_scanout.sv
// 4-bit single-port framebuffer: scan-out read path, write FIFO drain and hardware clear engine.
// Define FB_SCANOUT_PALETTE_EN to map pixel indices through a 16x12 palette instead of greyscale.
module framebuffer_scanout #(
    parameter int FB_DEPTH   = 76800,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_ce,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              blank_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              clear_req,
    input  logic [3:0]        clear_color,
    output logic              clear_busy,
    input  logic              pal_we,
    input  logic [3:0]        pal_idx,
    input  logic [11:0]       pal_rgb,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [3:0]        fb_mem [FB_DEPTH];

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [3:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [ADDR_W-1:0] head_addr;
    logic [3:0]        head_data;

    logic [ADDR_W-1:0] clr_cnt;
    logic [3:0]        clr_color;
    logic              clr_start;
    logic              clr_step;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [3:0]        mem_wdata;

    logic [3:0]        rd_data_p0;
    logic              oor_p0;
    logic              blank_p0;
    logic              hs_p0;
    logic              vs_p0;
    logic [3:0]        pix_idx;
    logic [11:0]       pix_rgb;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign head_data  = fifo_data[rd_ptr[PTR_W-1:0]];

    // Requests in the clear_req cycle are refused so the flush cannot lose an accepted write.
    assign wr_ready   = Reset && !fifo_full && (state == IDLE) && !clear_req;
    assign fifo_push  = wr_valid && wr_ready;
    assign clear_busy = (state == CLEAR);

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        clr_start  = 1'b0;
        clr_step   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt;
        mem_wdata  = clr_color;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt  = CLEAR;
                    fifo_flush = 1'b1;
                    clr_start  = 1'b1;
                end else if (!pix_ce && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    mem_waddr = head_addr;
                    mem_wdata = head_data;
                    mem_we    = (head_addr < DEPTH_A);
                end
            end
            CLEAR: begin
                if (!pix_ce) begin
                    clr_step = 1'b1;
                    mem_we   = 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (fifo_push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= wr_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (clr_start) begin
            clr_cnt   <= '0;
            clr_color <= clear_color;
        end else if (clr_step) begin
            clr_cnt   <= clr_cnt + ADDR_W'(1);
        end
    end

    // Stage p0: single-port RAM, scan read or write-slot write.
    always_ff @(posedge Clk) begin
        if (pix_ce) begin
            rd_data_p0 <= fb_mem[scan_addr];
            oor_p0     <= (scan_addr >= DEPTH_A);
        end else if (mem_we) begin
            fb_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign pix_idx = oor_p0 ? 4'h0 : rd_data_p0;

`ifdef FB_SCANOUT_PALETTE_EN
    logic [11:0] pal [16];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= {3{4'(i)}};
            end
        end else if (pal_we) begin
            pal[pal_idx] <= pal_rgb;
        end
    end

    assign pix_rgb = pal[pix_idx];
`else
    logic unused_pal;
    assign unused_pal = ^{pal_we, pal_idx, pal_rgb};
    assign pix_rgb    = {3{pix_idx}};
`endif

    // Stage p1: sync/blank delay line and colour output register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            blank_p0 <= 1'b0;
            hs_p0    <= 1'b1;
            vs_p0    <= 1'b1;
            VGA_HS   <= 1'b1;
            VGA_VS   <= 1'b1;
            VGA_R    <= 4'h0;
            VGA_G    <= 4'h0;
            VGA_B    <= 4'h0;
        end else begin
            blank_p0 <= blank_in;
            hs_p0    <= hs_in;
            vs_p0    <= vs_in;
            VGA_HS   <= hs_p0;
            VGA_VS   <= vs_p0;
            {VGA_R, VGA_G, VGA_B} <= blank_p0 ? pix_rgb : 12'h000;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout using a small framebuffer and a cycle-stamped scoreboard.
module tb_framebuffer_scanout;

    localparam int FB_DEPTH   = 1000;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              pix_ce = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic              blank_in = 1'b0;
    logic              hs_in = 1'b1;
    logic              vs_in = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [3:0]        wr_data = '0;
    logic              clear_req = 1'b0;
    logic [3:0]        clear_color = '0;
    logic              clear_busy;
    logic              pal_we = 1'b0;
    logic [3:0]        pal_idx = '0;
    logic [11:0]       pal_rgb = '0;
    logic [3:0]        VGA_R;
    logic [3:0]        VGA_G;
    logic [3:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;

    always #5 Clk = ~Clk;

    framebuffer_scanout #(
        .FB_DEPTH   (FB_DEPTH),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pix_ce      (pix_ce),
        .scan_addr   (scan_addr),
        .blank_in    (blank_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_rgb     (pal_rgb),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS)
    );

    typedef struct {
        int          due;
        bit          chk_rgb;
        logic [11:0] rgb;
        bit          chk_sync;
        logic        hs;
        logic        vs;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    logic [11:0] pal_m [16];

    function automatic logic [11:0] exp_rgb(input logic [3:0] idx);
`ifdef FB_SCANOUT_PALETTE_EN
        return pal_m[idx];
`else
        return {idx, idx, idx};
`endif
    endfunction

    task automatic pal_model_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            pal_m[i] = {v, v, v};
        end
    endtask

    // Advance one clock, then compare every scoreboard entry due in this cycle.
    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: entry due cycle %0d reached at cycle %0d", e.tag, e.due, cyc);
            end else if (e.chk_rgb && ({VGA_R, VGA_G, VGA_B} !== e.rgb)) begin
                errors++;
                $display("FAIL %s: rgb got %h expected %h (cycle %0d)", e.tag, {VGA_R, VGA_G, VGA_B}, e.rgb, cyc);
            end else if (e.chk_sync && ({VGA_HS, VGA_VS} !== {e.hs, e.vs})) begin
                errors++;
                $display("FAIL %s: hs/vs got %b%b expected %b%b (cycle %0d)", e.tag, VGA_HS, VGA_VS, e.hs, e.vs, cyc);
            end
        end
    endtask

    task automatic expect_rgb(input int lat, input logic [11:0] rgb, input string tag);
        exp_t e;
        e.due = cyc + lat; e.chk_rgb = 1'b1; e.rgb = rgb;
        e.chk_sync = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic scan(input logic [ADDR_W-1:0] a, input logic blank, input logic [11:0] rgb, input string tag);
        pix_ce = 1'b1; scan_addr = a; blank_in = blank;
        expect_rgb(2, rgb, tag);
        step();
        pix_ce = 1'b0;
        step();
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [3:0] d);
        bit done;
        done = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            done = wr_ready;
            step();
        end
        wr_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_wr: addr %0d not accepted, got ready=%b expected 1", a, wr_ready);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        pal_model_reset();
        repeat (3) step();
        checks++; if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin errors++; $display("FAIL rst_rgb: got %h expected 000", {VGA_R, VGA_G, VGA_B}); end
        checks++; if ({VGA_HS, VGA_VS} !== 2'b11) begin errors++; $display("FAIL rst_sync: got %b%b expected 11", VGA_HS, VGA_VS); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", wr_ready); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", clear_busy); end
        Reset = 1'b1;
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_write_scan();
        push_wr(ADDR_W'(5), 4'hA);
        repeat (2) step();
        expect_rgb(1, 12'h000, "scan_not_early");
        scan(ADDR_W'(5), 1'b1, exp_rgb(4'hA), "write_scan");
    endtask

    task automatic test_blanking();
        exp_t e;
        scan(ADDR_W'(5), 1'b0, 12'h000, "blank_rgb");
        for (int i = 0; i < 8; i++) begin
            hs_in = (i == 2) ? 1'b0 : 1'b1;
            vs_in = (i == 4) ? 1'b0 : 1'b1;
            e.due = cyc + 2; e.chk_rgb = 1'b0; e.rgb = '0;
            e.chk_sync = 1'b1; e.hs = hs_in; e.vs = vs_in; e.tag = "sync_delay";
            sb.push_back(e);
            step();
        end
        hs_in = 1'b1; vs_in = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] a [6];
        logic [3:0]        d [6];
        int k;
        a[0] = 10; a[1] = 11; a[2] = 12; a[3] = 12; a[4] = 14; a[5] = 15;
        d[0] = 1;  d[1] = 2;  d[2] = 3;  d[3] = 4;  d[4] = 5;  d[5] = 6;
        k = 0;
        pix_ce = 1'b1; scan_addr = '0; blank_in = 1'b0;
        for (int c = 0; c < 8 && k < 6; c++) begin
            wr_valid = 1'b1; wr_addr = a[k]; wr_data = d[k];
            #1;
            if (wr_ready) k++;
            step();
        end
        checks++; if (k !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", k); end
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", wr_ready); end
        for (int c = 0; c < 40 && k < 6; c++) begin
            pix_ce = (c % 2 == 1);
            wr_valid = 1'b1; wr_addr = a[k]; wr_data = d[k];
            #1;
            if (wr_ready) k++;
            step();
        end
        wr_valid = 1'b0; pix_ce = 1'b0;
        repeat (6) step();
        checks++; if (k !== 6) begin errors++; $display("FAIL bp_all_accepted: got %0d expected 6", k); end
        scan(ADDR_W'(10), 1'b1, exp_rgb(4'h1), "bp_read10");
        scan(ADDR_W'(11), 1'b1, exp_rgb(4'h2), "bp_read11");
        scan(ADDR_W'(12), 1'b1, exp_rgb(4'h4), "bp_read12_order");
        scan(ADDR_W'(14), 1'b1, exp_rgb(4'h5), "bp_read14");
        scan(ADDR_W'(15), 1'b1, exp_rgb(4'h6), "bp_read15");
    endtask

    task automatic test_out_of_range();
        push_wr(ADDR_W'(FB_DEPTH - 1), 4'h7);
        push_wr(ADDR_W'(FB_DEPTH), 4'hF);
        repeat (4) step();
        scan(ADDR_W'(FB_DEPTH - 1), 1'b1, exp_rgb(4'h7), "oor_keep_last");
        scan(ADDR_W'(FB_DEPTH), 1'b1, exp_rgb(4'h0), "oor_scan_depth");
        scan(ADDR_W'(1023), 1'b1, exp_rgb(4'h0), "oor_scan_max");
    endtask

    task automatic test_palette();
        pal_we = 1'b1; pal_idx = 4'hA; pal_rgb = 12'hF80;
        step();
        pal_we = 1'b0; pal_rgb = 12'h000;
`ifdef FB_SCANOUT_PALETTE_EN
        pal_m[4'hA] = 12'hF80;
`endif
        scan(ADDR_W'(5), 1'b1, exp_rgb(4'hA), "palette_lookup");
        scan(ADDR_W'(11), 1'b1, exp_rgb(4'h2), "palette_other");
    endtask

    task automatic test_clear();
        int  busy;
        bit  done;
        pix_ce = 1'b1; scan_addr = '0; blank_in = 1'b0;
        push_wr(ADDR_W'(20), 4'h9);
        push_wr(ADDR_W'(21), 4'h9);
        clear_req = 1'b1; clear_color = 4'h3;
        wr_valid = 1'b1; wr_addr = ADDR_W'(22); wr_data = 4'hC;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_low: got %b expected 0", wr_ready); end
        step();
        clear_req = 1'b0; clear_color = 4'h0; wr_valid = 1'b0;
        busy = 0; done = 1'b0;
        for (int c = 0; c < 3 * FB_DEPTH && !done; c++) begin
            pix_ce = (c % 2 == 0);
            #1;
            if (clear_busy) begin
                busy++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        pix_ce = 1'b0;
        checks++; if (busy !== 2 * FB_DEPTH) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected %0d", busy, 2 * FB_DEPTH); end
        repeat (4) step();
        for (int a = 0; a < FB_DEPTH; a++) begin
            scan(ADDR_W'(a), 1'b1, exp_rgb(4'h3), "clr_fill");
        end
    endtask

    task automatic test_clear_reset();
        pix_ce = 1'b0; clear_req = 1'b1; clear_color = 4'hE;
        step();
        clear_req = 1'b0; clear_color = 4'h0;
        for (int c = 0; c < 40; c++) begin
            pix_ce = (c % 2 == 0);
            clear_req = (c == 20);
            clear_color = (c == 20) ? 4'h5 : 4'h0;
            step();
        end
        clear_req = 1'b0; pix_ce = 1'b0;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clrrst_busy: got %b expected 1", clear_busy); end
        Reset = 1'b0;
        step();
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clrrst_busy_drop: got %b expected 0", clear_busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clrrst_ready_low: got %b expected 0", wr_ready); end
        Reset = 1'b1;
        pal_model_reset();
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clrrst_ready_back: got %b expected 1", wr_ready); end
        scan(ADDR_W'(0), 1'b1, exp_rgb(4'hE), "clrrst_partial_first");
        scan(ADDR_W'(10), 1'b1, exp_rgb(4'hE), "clrrst_partial_mid");
        scan(ADDR_W'(30), 1'b1, exp_rgb(4'h3), "clrrst_untouched");
        scan(ADDR_W'(FB_DEPTH - 1), 1'b1, exp_rgb(4'h3), "clrrst_untouched_last");
    endtask

    initial begin
        test_reset();
        test_write_scan();
        test_blanking();
        test_backpressure();
        test_out_of_range();
        test_palette();
        test_clear();
        test_clear_reset();
        repeat (4) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
